// File: rtl/param_datapath_core.sv
// Parametrised datapath core: register file, accumulator, ALU, zero flag and a timed memory-load path.
// Optional multiplier for opcode 8 is enabled by defining DATAPATH_MUL_EN.
module param_datapath_core #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned REG_AW      = 3,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [REG_AW-1:0] op_reg,
    input  logic [DATA_W-1:0] op_imm,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [DATA_W-1:0] ac_out,
    output logic [DATA_W-1:0] bus_out,
    output logic              z_flag,
    output logic              err,
    input  logic [REG_AW-1:0] reg_dbg_sel,
    output logic [DATA_W-1:0] reg_dbg_out
);

    localparam int unsigned     CntW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MEM_TIMEOUT);
    localparam logic [REG_AW:0] NumRegs = (REG_AW + 1)'(NUM_REGS);

    localparam logic [3:0] OpLdi    = 4'd1;
    localparam logic [3:0] OpWtr    = 4'd2;
    localparam logic [3:0] OpWta    = 4'd3;
    localparam logic [3:0] OpInc    = 4'd4;
    localparam logic [3:0] OpRst    = 4'd5;
    localparam logic [3:0] OpAdd    = 4'd6;
    localparam logic [3:0] OpSub    = 4'd7;
    localparam logic [3:0] OpLdm    = 4'd9;
    localparam logic [3:0] OpClrErr = 4'd10;
`ifdef DATAPATH_MUL_EN
    localparam logic [3:0] OpMul    = 4'd8;
`endif

    typedef enum logic [0:0] {StIdle, StMemWait} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [DATA_W-1:0]   ac_q, ac_d, bus_q, bus_d;
    logic                z_q, z_d, err_q, err_d, req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic                reg_ok, dbg_ok;
    logic [DATA_W-1:0]   rd_val;
    logic                ac_wr, reg_wr;
    logic [DATA_W-1:0]   ac_wdata, reg_wdata;

    // Out-of-range indices read as zero; writes to them are dropped below.
    assign reg_ok = ({1'b0, op_reg} < NumRegs);
    assign dbg_ok = ({1'b0, reg_dbg_sel} < NumRegs);
    assign rd_val = reg_ok ? regs_q[op_reg] : '0;

`ifdef DATAPATH_MUL_EN
    logic [DATA_W-1:0] mul_res;
    assign mul_res = ac_q * rd_val;
`endif

    always_comb begin
        state_d   = state_q;
        regs_d    = regs_q;
        ac_d      = ac_q;
        bus_d     = bus_q;
        z_d       = z_q;
        err_d     = err_q;
        req_d     = req_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        ac_wr     = 1'b0;
        reg_wr    = 1'b0;
        ac_wdata  = '0;
        reg_wdata = '0;

        unique case (state_q)
            StIdle: begin
                if (op_valid) begin
                    case (op_code)
                        OpLdi: begin ac_wr = 1'b1; ac_wdata = op_imm; end
                        OpWtr: begin reg_wr = 1'b1; reg_wdata = ac_q; end
                        OpWta: begin ac_wr = 1'b1; ac_wdata = rd_val; end
                        OpInc: begin reg_wr = 1'b1; reg_wdata = rd_val + 1'b1; end
                        OpRst: begin reg_wr = 1'b1; reg_wdata = '0; end
                        OpAdd: begin ac_wr = 1'b1; ac_wdata = ac_q + rd_val; end
                        OpSub: begin ac_wr = 1'b1; ac_wdata = ac_q - rd_val; end
`ifdef DATAPATH_MUL_EN
                        OpMul: begin ac_wr = 1'b1; ac_wdata = mul_res; end
`endif
                        OpLdm: begin
                            req_d   = 1'b1;
                            addr_d  = ADDR_W'(rd_val);
                            cnt_d   = '0;
                            state_d = StMemWait;
                        end
                        OpClrErr: err_d = 1'b0;
                        default: ;
                    endcase
                end
            end
            StMemWait: begin
                // Data arriving on the timeout edge still completes the load.
                if (mem_rvalid) begin
                    ac_wr    = 1'b1;
                    ac_wdata = mem_rdata;
                    req_d    = 1'b0;
                    state_d  = StIdle;
                end else if (cnt_q + 1'b1 == CntMax) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (ac_wr) begin
            ac_d  = ac_wdata;
            bus_d = ac_wdata;
            z_d   = (ac_wdata == '0);
        end
        if (reg_wr) begin
            bus_d = reg_wdata;
            if (reg_ok) regs_d[op_reg] = reg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
            ac_q    <= '0;
            bus_q   <= '0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            ac_q    <= ac_d;
            bus_q   <= bus_d;
            z_q     <= z_d;
            err_q   <= err_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign op_ready    = (state_q == StIdle);
    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign ac_out      = ac_q;
    assign bus_out     = bus_q;
    assign z_flag      = z_q;
    assign err         = err_q;
    assign reg_dbg_out = dbg_ok ? regs_q[reg_dbg_sel] : '0;

endmodule

// File: tb/tb_param_datapath_core.sv
// Scoreboard bench for param_datapath_core: stimulus pushes expected state per op,
// a monitor pops and compares on each op completion.
module tb_param_datapath_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op_code = '0;
    logic [2:0]  op_reg = '0;
    logic [15:0] op_imm = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] ac_out, bus_out;
    logic        z_flag, err;
    logic [2:0]  reg_dbg_sel = '0;
    logic [15:0] reg_dbg_out;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [15:0] ac;
        logic [15:0] bus;
        logic        z;
        logic        err;
        logic [15:0] dval;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    param_datapath_core #(
        .DATA_W(16), .NUM_REGS(6), .REG_AW(3), .ADDR_W(16), .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_reg(op_reg), .op_imm(op_imm),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .ac_out(ac_out), .bus_out(bus_out),
        .z_flag(z_flag), .err(err), .reg_dbg_sel(reg_dbg_sel), .reg_dbg_out(reg_dbg_out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    // Monitor: an op completes on its accept edge (non-LDM) or when mem_req falls (LDM).
    initial begin
        logic done, was_req;
        exp_t e;
        forever begin
            @(posedge clk);
            done    = rst_n && op_valid && op_ready && (op_code != 4'd9);
            was_req = mem_req;
            #1;
            if (rst_n && was_req && !mem_req) done = 1'b1;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_ac"}, 32'(ac_out), 32'(e.ac));
                    chk({e.name, "_bus"}, 32'(bus_out), 32'(e.bus));
                    chk({e.name, "_z"}, 32'(z_flag), 32'(e.z));
                    chk({e.name, "_err"}, 32'(err), 32'(e.err));
                    chk({e.name, "_dbg"}, 32'(reg_dbg_out), 32'(e.dval));
                end
            end
        end
    end

    task automatic issue(input bit push, input string nm, input logic [3:0] code,
                         input logic [2:0] r, input logic [15:0] imm,
                         input logic [15:0] eac, input logic [15:0] ebus, input logic ez,
                         input logic eerr, input logic [2:0] dsel, input logic [15:0] dval);
        exp_t e;
        int n;
        e.name = nm; e.ac = eac; e.bus = ebus; e.z = ez; e.err = eerr; e.dval = dval;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        op_valid = 1'b1; op_code = code; op_reg = r; op_imm = imm; reg_dbg_sel = dsel;
        n = 0;
        forever begin
            @(posedge clk);
            if (op_ready) break;
            n++;
            if (n > 50) begin
                chk({nm, "_accept_timeout"}, 32'd1, 32'd0);
                break;
            end
        end
    endtask

    // Drives rvalid on the rv_at-th stalled cycle (0 = never); returns stalled cycle count.
    task automatic ldm_wait(input string nm, input int rv_at, input logic [15:0] rdata,
                            input logic [15:0] eaddr, output int low);
        low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            op_valid = 1'b0;
            if (!mem_req && op_ready) break;
            low++;
            if (i == 0) begin
                chk({nm, "_req"}, 32'(mem_req), 32'd1);
                chk({nm, "_addr"}, 32'(mem_addr), 32'(eaddr));
                chk({nm, "_ready_low"}, 32'(op_ready), 32'd0);
            end
            mem_rvalid = (low == rv_at);
            mem_rdata  = rdata;
        end
        mem_rvalid = 1'b0;
    endtask

    initial begin
        int low;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        // Reset state
        @(negedge clk);
        chk("rst_ac", 32'(ac_out), 32'd0);
        chk("rst_bus", 32'(bus_out), 32'd0);
        chk("rst_z", 32'(z_flag), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_dbg", 32'(reg_dbg_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back register traffic
        issue(1, "ldi5",  4'd1, 3'd0, 16'd5, 16'd5, 16'd5, 0, 0, 3'd0, 16'd0);
        issue(1, "wtr2",  4'd2, 3'd2, 16'd0, 16'd5, 16'd5, 0, 0, 3'd2, 16'd5);
        issue(1, "inc2",  4'd4, 3'd2, 16'd0, 16'd5, 16'd6, 0, 0, 3'd2, 16'd6);
        issue(1, "wta2",  4'd3, 3'd2, 16'd0, 16'd6, 16'd6, 0, 0, 3'd2, 16'd6);
        // Zero flag and subtraction wrap
        issue(1, "ldi3",  4'd1, 3'd0, 16'd3, 16'd3, 16'd3, 0, 0, 3'd0, 16'd0);
        issue(1, "sub0",  4'd7, 3'd0, 16'd0, 16'd3, 16'd3, 0, 0, 3'd0, 16'd0);
        issue(1, "ldi0",  4'd1, 3'd0, 16'd0, 16'd0, 16'd0, 1, 0, 3'd0, 16'd0);
        issue(1, "ldi4",  4'd1, 3'd0, 16'd4, 16'd4, 16'd4, 0, 0, 3'd0, 16'd0);
        issue(1, "wtr1",  4'd2, 3'd1, 16'd0, 16'd4, 16'd4, 0, 0, 3'd1, 16'd4);
        issue(1, "ldi3b", 4'd1, 3'd0, 16'd3, 16'd3, 16'd3, 0, 0, 3'd1, 16'd4);
        issue(1, "sub1",  4'd7, 3'd1, 16'd0, 16'hFFFF, 16'hFFFF, 0, 0, 3'd1, 16'd4);
        issue(1, "add1",  4'd6, 3'd1, 16'd0, 16'd3, 16'd3, 0, 0, 3'd1, 16'd4);
        // Out-of-range register index (NUM_REGS=6)
        issue(1, "wtr7",  4'd2, 3'd7, 16'd0, 16'd3, 16'd3, 0, 0, 3'd7, 16'd0);
        issue(1, "wta7",  4'd3, 3'd7, 16'd0, 16'd0, 16'd0, 1, 0, 3'd7, 16'd0);
        // RST and INC wrap; z holds on register writes
        issue(1, "ldi9",  4'd1, 3'd0, 16'd9, 16'd9, 16'd9, 0, 0, 3'd3, 16'd0);
        issue(1, "wtr3",  4'd2, 3'd3, 16'd0, 16'd9, 16'd9, 0, 0, 3'd3, 16'd9);
        issue(1, "rst3",  4'd5, 3'd3, 16'd0, 16'd9, 16'd0, 0, 0, 3'd3, 16'd0);
        issue(1, "ldiff", 4'd1, 3'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 3'd4, 16'd0);
        issue(1, "wtr4",  4'd2, 3'd4, 16'd0, 16'hFFFF, 16'hFFFF, 0, 0, 3'd4, 16'hFFFF);
        issue(1, "inc4",  4'd4, 3'd4, 16'd0, 16'hFFFF, 16'd0, 0, 0, 3'd4, 16'd0);
        // NOP-like ops change nothing
        issue(1, "nop0",  4'd0, 3'd4, 16'h55, 16'hFFFF, 16'd0, 0, 0, 3'd4, 16'd0);
        issue(1, "nop12", 4'd12, 3'd4, 16'h55, 16'hFFFF, 16'd0, 0, 0, 3'd4, 16'd0);
        issue(1, "clr0",  4'd10, 3'd4, 16'h55, 16'hFFFF, 16'd0, 0, 0, 3'd4, 16'd0);
        // Memory load with delayed rvalid
        issue(1, "ldi40", 4'd1, 3'd0, 16'h0040, 16'h0040, 16'h0040, 0, 0, 3'd1, 16'd4);
        issue(1, "wtr1b", 4'd2, 3'd1, 16'd0, 16'h0040, 16'h0040, 0, 0, 3'd1, 16'h0040);
        issue(1, "ldm_a", 4'd9, 3'd1, 16'd0, 16'h1234, 16'h1234, 0, 0, 3'd1, 16'h0040);
        ldm_wait("ldm_a", 3, 16'h1234, 16'h0040, low);
        chk("ldm_a_stall", 32'(low), 32'd3);
        issue(1, "ldm_z", 4'd9, 3'd1, 16'd0, 16'd0, 16'd0, 1, 0, 3'd1, 16'h0040);
        ldm_wait("ldm_z", 1, 16'h0000, 16'h0040, low);
        chk("ldm_z_stall", 32'(low), 32'd1);
        // Timeout, then CLRERR
        issue(1, "ldi77", 4'd1, 3'd0, 16'h0077, 16'h0077, 16'h0077, 0, 0, 3'd1, 16'h0040);
        issue(1, "ldm_t", 4'd9, 3'd1, 16'd0, 16'h0077, 16'h0077, 0, 1, 3'd1, 16'h0040);
        ldm_wait("ldm_t", 0, 16'hBEEF, 16'h0040, low);
        chk("ldm_t_req_cycles", 32'(low), 32'd15);
        issue(1, "clrerr", 4'd10, 3'd1, 16'd0, 16'h0077, 16'h0077, 0, 0, 3'd1, 16'h0040);
        // rvalid while idle is ignored
        @(negedge clk);
        op_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_rvalid = 1'b0;
        issue(1, "idle_rv", 4'd0, 3'd1, 16'd0, 16'h0077, 16'h0077, 0, 0, 3'd1, 16'h0040);
        // Multiply
        issue(1, "ldi100", 4'd1, 3'd0, 16'h0100, 16'h0100, 16'h0100, 0, 0, 3'd3, 16'd0);
        issue(1, "wtr3b",  4'd2, 3'd3, 16'd0, 16'h0100, 16'h0100, 0, 0, 3'd3, 16'h0100);
        issue(1, "ldi102", 4'd1, 3'd0, 16'h0102, 16'h0102, 16'h0102, 0, 0, 3'd3, 16'h0100);
`ifdef DATAPATH_MUL_EN
        issue(1, "mul3",   4'd8, 3'd3, 16'd0, 16'h0200, 16'h0200, 0, 0, 3'd3, 16'h0100);
`else
        issue(1, "mul3",   4'd8, 3'd3, 16'd0, 16'h0102, 16'h0102, 0, 0, 3'd3, 16'h0100);
`endif
        // Reset in the middle of a load
        issue(0, "ldm_r", 4'd9, 3'd1, 16'd0, 16'd0, 16'd0, 0, 0, 3'd1, 16'd0);
        @(negedge clk);
        op_valid = 1'b0;
        chk("ldm_r_req_before", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_ac", 32'(ac_out), 32'd0);
        chk("midrst_ready", 32'(op_ready), 32'd1);
        chk("midrst_dbg", 32'(reg_dbg_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
